// File: rtl/axi_sram_slave_pkg.sv
// rtl/axi_sram_slave_pkg.sv - shared widths, AXI codes and FSM encoding for axi_sram_slave
package axi_sram_slave_pkg;

  localparam int L_ID_W   = 4;
  localparam int L_ADDR_W = 32;
  localparam int L_DATA_W = 32;
  localparam int L_RAM_AW = 14;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_DATA = 3'd3,
    S_WR_RESP = 3'd4
  } state_t;

  // Only 4-byte beats and FIXED/INCR bursts are served; anything else answers SLVERR.
  function automatic logic attr_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != 3'd2) | burst[1];
  endfunction

endpackage

// File: rtl/axi_sram_beat_gen.sv
// rtl/axi_sram_beat_gen.sv - burst address/beat counter shared by the read and write paths
module axi_sram_beat_gen
  import axi_sram_slave_pkg::*;
#(
  parameter int ADDR_W = L_ADDR_W,
  parameter int RAM_AW = L_RAM_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [3:0]        load_len,
  input  logic [1:0]        load_burst,
  input  logic              advance,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              last
);

  logic [ADDR_W-1:0] addr;
  logic [3:0]        len;
  logic [3:0]        cnt;
  logic [1:0]        burst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr  <= '0;
      len   <= '0;
      cnt   <= '0;
      burst <= BURST_FIXED;
    end else if (load) begin
      addr  <= load_addr;
      len   <= load_len;
      cnt   <= '0;
      burst <= load_burst;
    end else if (advance) begin
      cnt <= cnt + 4'd1;
      if (burst == BURST_INCR) begin
        addr <= addr + ADDR_W'(4);
      end
    end
  end

  // Upper address bits alias onto the SRAM; the byte offset never reaches it.
  assign ram_addr = addr[RAM_AW+1:2];
  assign last     = (cnt == len);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[ADDR_W-1:RAM_AW+2], addr[1:0]};

endmodule

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI3 single-outstanding responder mapped onto one synchronous SRAM
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int ID_W   = L_ID_W,
  parameter int ADDR_W = L_ADDR_W,
  parameter int DATA_W = L_DATA_W,
  parameter int RAM_AW = L_RAM_AW
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [3:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic [1:0]          arlock,
  input  logic [3:0]          arcache,
  input  logic [2:0]          arprot,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [3:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic [1:0]          awlock,
  input  logic [3:0]          awcache,
  input  logic [2:0]          awprot,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_W-1:0]     wid,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  output logic                ram_en,
  output logic [DATA_W/8-1:0] ram_we,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int STRB_W = DATA_W / 8;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   id_q;
  logic              err_q;
  logic              werr_q;
  logic              ar_hs, aw_hs, load, wr_beat, advance, last;
  logic [ADDR_W-1:0] load_addr;
  logic [3:0]        load_len;
  logic [1:0]        load_burst;
  logic [RAM_AW-1:0] beat_addr;

  // Reads win a same-cycle race: AW is held off while arvalid is up.
  assign arready = aresetn & (state == S_IDLE);
  assign awready = aresetn & (state == S_IDLE) & ~arvalid;
  assign ar_hs   = arvalid & arready;
  assign aw_hs   = awvalid & awready;
  assign load    = ar_hs | aw_hs;

  assign load_addr  = ar_hs ? araddr  : awaddr;
  assign load_len   = ar_hs ? arlen   : awlen;
  assign load_burst = ar_hs ? arburst : awburst;

  assign wr_beat = (state == S_WR_DATA) & wvalid;
  assign advance = ((state == S_RD_DATA) & rready) | wr_beat;

  axi_sram_beat_gen #(
    .ADDR_W (ADDR_W),
    .RAM_AW (RAM_AW)
  ) u_beat_gen (
    .clk        (aclk),
    .rst_n      (aresetn),
    .load       (load),
    .load_addr  (load_addr),
    .load_len   (load_len),
    .load_burst (load_burst),
    .advance    (advance),
    .ram_addr   (beat_addr),
    .last       (last)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state  <= S_IDLE;
      id_q   <= '0;
      err_q  <= 1'b0;
      werr_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        id_q   <= ar_hs ? arid : awid;
        err_q  <= ar_hs ? attr_err(arsize, arburst) : attr_err(awsize, awburst);
        werr_q <= 1'b0;
      end else if (wr_beat && (wlast != last)) begin
        werr_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rvalid    = 1'b0;
    rid       = '0;
    rdata     = '0;
    rresp     = RESP_OKAY;
    rlast     = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    bid       = '0;
    bresp     = RESP_OKAY;
    ram_en    = 1'b0;
    ram_we    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (state)
      S_IDLE: begin
        if (ar_hs) begin
          state_nxt = S_RD_REQ;
        end else if (aw_hs) begin
          state_nxt = S_WR_DATA;
        end
      end
      S_RD_REQ: begin
        ram_en    = ~err_q;
        ram_addr  = beat_addr;
        state_nxt = S_RD_DATA;
      end
      S_RD_DATA: begin
        // ram_rdata holds until the next ram_en, so R stays stable under backpressure.
        rvalid = 1'b1;
        rid    = id_q;
        rdata  = err_q ? '0 : ram_rdata;
        rresp  = err_q ? RESP_SLVERR : RESP_OKAY;
        rlast  = last;
        if (rready) begin
          state_nxt = last ? S_IDLE : S_RD_REQ;
        end
      end
      S_WR_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          ram_en    = ~err_q;
          ram_we    = wstrb & {STRB_W{~err_q}};
          ram_addr  = beat_addr;
          ram_wdata = wdata;
          if (last) begin
            state_nxt = S_WR_RESP;
          end
        end
      end
      S_WR_RESP: begin
        bvalid = 1'b1;
        bid    = id_q;
        bresp  = (err_q | werr_q) ? RESP_SLVERR : RESP_OKAY;
        if (bready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  logic unused_inputs;
  assign unused_inputs = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - randomized self-checking bench for axi_sram_slave with SRAM model
module tb_axi_sram_slave;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int RAM_AW = 14;
  localparam int WORDS  = 1 << RAM_AW;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [ID_W-1:0]   arid = '0, awid = '0, wid = '0, rid, bid;
  logic [ADDR_W-1:0] araddr = '0, awaddr = '0;
  logic [3:0]        arlen = '0, awlen = '0, arcache = '0, awcache = '0;
  logic [2:0]        arsize = '0, awsize = '0, arprot = '0, awprot = '0;
  logic [1:0]        arburst = '0, awburst = '0, arlock = '0, awlock = '0;
  logic              arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic              rready = 1'b1, bready = 1'b1;
  logic              arready, awready, rvalid, rlast, wready, bvalid;
  logic [1:0]        rresp, bresp;
  logic [DATA_W-1:0] rdata, wdata = '0, ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic [3:0]        wstrb = '0, ram_we;
  logic              ram_en;
  logic [RAM_AW-1:0] ram_addr;

  axi_sram_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_AW(RAM_AW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // SRAM model with a backdoor preload port
  logic [31:0]       mem [0:WORDS-1];
  logic              pre_en = 1'b0;
  logic [RAM_AW-1:0] pre_idx = '0;
  logic [31:0]       pre_val = '0;
  always @(posedge aclk) begin
    if (pre_en) begin
      mem[pre_idx] <= pre_val;
    end else if (ram_en) begin
      if (|ram_we) begin
        for (int b = 0; b < 4; b++) if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  int cyc = 0, en_cnt = 0, we_cnt = 0, bad_we = 0;
  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (ram_en) en_cnt <= en_cnt + 1;
    if (ram_en && |ram_we) we_cnt <= we_cnt + 1;
    if (ram_en && |ram_we && !wvalid) bad_we <= bad_we + 1;
  end

  // Reference: contents expected in SRAM, indexed by word
  logic [31:0] ref_mem [0:WORDS-1];
  int checks = 0;
  int errors = 0;

  function automatic int widx(input logic [31:0] base, input int k, input logic [1:0] burst);
    logic [31:0] a;
    a = (burst == 2'b01) ? base + 32'(4 * k) : base;
    return int'(a[15:2]);
  endfunction

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int stall_beat, input int stall_cyc, output int done_cyc);
    logic err;
    int n;
    logic [31:0] exp_data, hold_data;
    logic hold_last;
    err = (size != 3'd2) || burst[1];
    done_cyc = 0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    arlock = 2'($urandom); arcache = 4'($urandom); arprot = 3'($urandom);
    arvalid = 1'b1; rready = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 200) begin @(negedge aclk); #1; n++; end
    if (!arready) begin
      checks++; errors++; $display("FAIL ar_timeout got arready=%b exp 1", arready);
      arvalid = 1'b0; return;
    end
    @(posedge aclk);
    @(negedge aclk);
    arvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      n = 0;
      while (!rvalid && n < 50) begin @(negedge aclk); n++; end
      checks++;
      if (n != 1) begin errors++; $display("FAIL r_latency beat %0d got %0d exp 1", k, n); end
      if (!rvalid) return;
      exp_data = err ? 32'h0 : ref_mem[widx(addr, k, burst)];
      checks++;
      if (rdata !== exp_data) begin errors++; $display("FAIL rdata beat %0d got %h exp %h", k, rdata, exp_data); end
      checks++;
      if (rid !== id) begin errors++; $display("FAIL rid got %h exp %h", rid, id); end
      checks++;
      if (rresp !== (err ? 2'b10 : 2'b00)) begin errors++; $display("FAIL rresp got %b exp %b", rresp, err ? 2'b10 : 2'b00); end
      checks++;
      if (rlast !== (k == int'(len))) begin errors++; $display("FAIL rlast beat %0d got %b exp %b", k, rlast, k == int'(len)); end
      checks++;
      if ({arready, awready} !== 2'b00) begin errors++; $display("FAIL addr_ready_in_burst got %b exp 00", {arready, awready}); end
      if (k == stall_beat) begin
        hold_data = rdata; hold_last = rlast;
        rready = 1'b0;
        repeat (stall_cyc) begin
          @(negedge aclk);
          checks++;
          if ({rvalid, rdata, rid, rlast} !== {1'b1, hold_data, id, hold_last}) begin
            errors++; $display("FAIL r_stall_stable got %b/%h/%h/%b", rvalid, rdata, rid, rlast);
          end
        end
        rready = 1'b1;
      end
      @(posedge aclk);
      @(negedge aclk);
    end
    done_cyc = cyc;
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [63:0] strb_pat,
                           input bit bad_wlast, input int gap, input int bready_stall, output int aw_cyc);
    logic err;
    int n, idx;
    logic [31:0] d;
    logic [3:0] s;
    logic [1:0] exp_resp;
    err = (size != 3'd2) || burst[1];
    exp_resp = (err || bad_wlast) ? 2'b10 : 2'b00;
    aw_cyc = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    awlock = 2'($urandom); awcache = 4'($urandom); awprot = 3'($urandom);
    awvalid = 1'b1;
    #1;
    n = 0;
    while (!awready && n < 200) begin @(negedge aclk); #1; n++; end
    if (!awready) begin
      checks++; errors++; $display("FAIL aw_timeout got awready=%b exp 1", awready);
      awvalid = 1'b0; return;
    end
    aw_cyc = cyc;
    @(posedge aclk);
    @(negedge aclk);
    awvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      if (gap > 0) begin wvalid = 1'b0; repeat (gap) @(negedge aclk); end
      d = $urandom; s = strb_pat[4*k +: 4];
      wdata = d; wstrb = s; wid = 4'($urandom);
      wlast = (k == int'(len)) ^ (bad_wlast && k == 0);
      wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin @(negedge aclk); n++; end
      if (!wready) begin
        checks++; errors++; $display("FAIL wready_timeout beat %0d got 0 exp 1", k);
        wvalid = 1'b0; return;
      end
      @(posedge aclk);
      if (!err) begin
        idx = widx(addr, k, burst);
        for (int b = 0; b < 4; b++) if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
      end
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge aclk); n++; end
    checks++;
    if ({bvalid, bid, bresp} !== {1'b1, id, exp_resp}) begin
      errors++; $display("FAIL b_resp got v=%b id=%h resp=%b exp v=1 id=%h resp=%b", bvalid, bid, bresp, id, exp_resp);
    end
    if (bready_stall > 0) begin
      bready = 1'b0;
      repeat (bready_stall) begin
        @(negedge aclk);
        checks++;
        if ({bvalid, bresp} !== {1'b1, exp_resp}) begin errors++; $display("FAIL b_hold got %b/%b", bvalid, bresp); end
      end
      bready = 1'b1;
    end
    @(posedge aclk);
    @(negedge aclk);
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL b_drop got %b exp 0", bvalid); end
  endtask

  task automatic prefill();
    for (int i = 0; i < WORDS; i++) begin
      @(negedge aclk);
      pre_en = 1'b1; pre_idx = RAM_AW'(i);
      pre_val = (i == 7) ? 32'hDEADBEEF : $urandom;
      ref_mem[i] = pre_val;
    end
    @(negedge aclk);
    pre_en = 1'b0;
  endtask

  task automatic test_reset();
    arvalid = 1'b1; awvalid = 1'b1;
    #1;
    checks++;
    if ({arready, awready, wready, rvalid, bvalid, ram_en} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 000000", {arready, awready, wready, rvalid, bvalid, ram_en});
    end
    checks++;
    if ({rdata, rid, rresp, rlast, bid, bresp, ram_we, ram_addr, ram_wdata} !== '0) begin
      errors++; $display("FAIL reset_data got rdata=%h ram_addr=%h ram_we=%h", rdata, ram_addr, ram_we);
    end
    arvalid = 1'b0; awvalid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    checks++;
    if ({arready, awready} !== 2'b11) begin errors++; $display("FAIL idle_ready got %b exp 11", {arready, awready}); end
  endtask

  task automatic test_single_read();
    int c, e0;
    e0 = en_cnt;
    axi_read(4'd3, 32'h1C, 4'd0, 3'd2, 2'b01, -1, 0, c);
    checks++;
    if (en_cnt - e0 !== 1) begin errors++; $display("FAIL single_read_en got %0d exp 1", en_cnt - e0); end
  endtask

  task automatic test_incr_write();
    int c, w0;
    w0 = we_cnt;
    axi_write(4'd9, 32'h100, 4'd3, 3'd2, 2'b01, 64'h0C3F, 1'b0, 0, 0, c);
    checks++;
    if (we_cnt - w0 !== 3) begin errors++; $display("FAIL strobe_writes got %0d exp 3", we_cnt - w0); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem[16'h40 + k] !== ref_mem[16'h40 + k]) begin
        errors++; $display("FAIL merge word %0d got %h exp %h", k, mem[16'h40 + k], ref_mem[16'h40 + k]);
      end
    end
    axi_read(4'd2, 32'h100, 4'd3, 3'd2, 2'b01, -1, 0, c);
  endtask

  task automatic test_collision();
    int rd_done, aw_cyc;
    rd_done = 0; aw_cyc = 0;
    fork
      axi_read(4'd5, 32'h0000_0200, 4'd2, 3'd2, 2'b01, -1, 0, rd_done);
      axi_write(4'd6, 32'h0000_0300, 4'd1, 3'd2, 2'b01, 64'hFF, 1'b0, 0, 0, aw_cyc);
    join
    checks++;
    if (!(aw_cyc >= rd_done && rd_done > 0)) begin
      errors++; $display("FAIL read_priority got aw_cyc=%0d exp >= %0d", aw_cyc, rd_done);
    end
    axi_read(4'd6, 32'h0000_0300, 4'd1, 3'd2, 2'b01, -1, 0, rd_done);
  endtask

  task automatic test_errors();
    int c, e0, w0;
    e0 = en_cnt;
    axi_read(4'd1, 32'h40, 4'd1, 3'd1, 2'b01, -1, 0, c);
    checks++;
    if (en_cnt !== e0) begin errors++; $display("FAIL err_read_en got %0d exp %0d", en_cnt, e0); end
    e0 = en_cnt; w0 = we_cnt;
    axi_write(4'd4, 32'h80, 4'd2, 3'd2, 2'b10, 64'hFFF, 1'b0, 0, 0, c);
    checks++;
    if ({en_cnt, we_cnt} !== {e0, w0}) begin errors++; $display("FAIL wrap_write_ram got en=%0d we=%0d", en_cnt - e0, we_cnt - w0); end
    axi_read(4'd4, 32'h80, 4'd2, 3'd2, 2'b01, -1, 0, c);
    axi_write(4'd7, 32'h500, 4'd2, 3'd2, 2'b01, 64'hFFF, 1'b1, 0, 0, c);
    axi_read(4'd7, 32'h500, 4'd2, 3'd2, 2'b01, -1, 0, c);
  endtask

  task automatic test_backpressure();
    int c;
    axi_write(4'd8, 32'h600, 4'd3, 3'd2, 2'b01, 64'hFFFF, 1'b0, 1, 4, c);
    axi_read(4'd8, 32'h600, 4'd3, 3'd2, 2'b01, 1, 5, c);
    axi_write(4'd10, 32'hFFFF_FFF8, 4'd3, 3'd2, 2'b01, 64'hFFFF, 1'b0, 0, 0, c);
    axi_read(4'd11, 32'hFFFF_FFF8, 4'd3, 3'd2, 2'b01, 3, 2, c);
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] d;
    int c;
    awid = 4'd12; awaddr = 32'h700; awlen = 4'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    awvalid = 1'b0;
    d = $urandom;
    wdata = d; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    @(posedge aclk);
    ref_mem[16'h1C0] = d;
    @(negedge aclk);
    wdata = $urandom;
    #1;
    aresetn = 1'b0;
    #1;
    checks++;
    if ({arready, awready, rvalid, wready, bvalid, ram_en, |ram_we} !== 7'b0) begin
      errors++; $display("FAIL mid_reset got %b exp 0000000", {arready, awready, rvalid, wready, bvalid, ram_en, |ram_we});
    end
    @(negedge aclk);
    wvalid = 1'b0;
    aresetn = 1'b1;
    @(negedge aclk);
    checks++;
    if ({arready, bvalid} !== 2'b10) begin errors++; $display("FAIL post_reset_idle got %b exp 10", {arready, bvalid}); end
    axi_read(4'd13, 32'h700, 4'd3, 3'd2, 2'b01, -1, 0, c);
  endtask

  task automatic test_random();
    logic [31:0] base;
    logic [3:0] len;
    logic [1:0] burst;
    int c;
    for (int t = 0; t < 12; t++) begin
      base  = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, WORDS - 1)) << 2);
      len   = 4'($urandom_range(0, 15));
      burst = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00;
      axi_write(4'($urandom), base, len, 3'd2, burst, {$urandom, $urandom}, 1'b0,
                $urandom_range(0, 2), $urandom_range(0, 3), c);
      axi_read(4'($urandom), base, len, 3'd2, burst, $urandom_range(0, int'(len)),
               $urandom_range(0, 3), c);
    end
    checks++;
    if (bad_we !== 0) begin errors++; $display("FAIL write_without_wvalid got %0d exp 0", bad_we); end
  endtask

  initial begin
    prefill();
    test_reset();
    test_single_read();
    test_incr_write();
    test_collision();
    test_errors();
    test_backpressure();
    test_reset_mid_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
